// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch front end.
// Owns the fetch PC, issues one word request at a time to instruction memory,
// and buffers returned instructions in a 2-entry queue for decode.
// Redirects from the next-PC calculator flush the queue and discard any
// response still in flight.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:2] redirect_pc,
    output logic [31:2] pc_plus4,
    output logic        imem_req,
    output logic [31:2] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:2] if_pc,
    output logic [31:0] if_instr,
    input  logic        id_ready
);

    localparam logic [31:2] ResetWord = RESET_PC[31:2];

    logic [31:2] fetchPc_q,     fetchPc_d;
    logic [31:2] inflightPc_q,  inflightPc_d;
    logic        outstanding_q, outstanding_d;
    logic        drop_q,        drop_d;
    logic [1:0]  count_q,       count_d;
    logic [31:2] headPc_q,      headPc_d;
    logic [31:0] headInstr_q,   headInstr_d;
    logic [31:2] tailPc_q,      tailPc_d;
    logic [31:0] tailInstr_q,   tailInstr_d;

    logic        pop;
    logic        rspAccept;
    logic        push;
    logic        pushOk;
    logic        grant;
    logic [2:0]  creditUse;
    logic [1:0]  wrIdx;

    assign if_valid  = (count_q != 2'd0);
    assign if_pc     = headPc_q;
    assign if_instr  = headInstr_q;
    assign imem_addr = fetchPc_q;
    assign pc_plus4  = fetchPc_q + 30'd1;

    // Handshake qualifiers and request credit: queue slots already used plus
    // the response still owed must leave room once this cycle's pop is counted.
    always_comb begin
        pop       = if_valid & id_ready;
        rspAccept = imem_rvalid & outstanding_q;
        push      = rspAccept & ~drop_q;
        creditUse = {1'b0, count_q} + {2'b00, outstanding_q} - {2'b00, pop};
        imem_req  = ~rst & ~redirect_valid & (creditUse < 3'd2)
                    & (~outstanding_q | imem_rvalid);
        grant     = imem_req & imem_gnt;
        wrIdx     = count_q - {1'b0, pop};
        pushOk    = push & (wrIdx != 2'd2);
    end

    // Next-state logic: redirect flushes the queue and marks a pending
    // response as stale; otherwise advance the PC on grant and push/pop.
    always_comb begin
        fetchPc_d     = fetchPc_q;
        inflightPc_d  = inflightPc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        count_d       = count_q;
        headPc_d      = headPc_q;
        headInstr_d   = headInstr_q;
        tailPc_d      = tailPc_q;
        tailInstr_d   = tailInstr_q;

        if (redirect_valid) begin
            fetchPc_d = redirect_pc;
            count_d   = 2'd0;
            if (outstanding_q && !imem_rvalid) begin
                outstanding_d = 1'b1;
                drop_d        = 1'b1;
            end else begin
                outstanding_d = 1'b0;
                drop_d        = 1'b0;
            end
        end else begin
            if (rspAccept) begin
                outstanding_d = 1'b0;
                drop_d        = 1'b0;
            end
            if (grant) begin
                inflightPc_d  = fetchPc_q;
                fetchPc_d     = fetchPc_q + 30'd1;
                outstanding_d = 1'b1;
            end
            if (pop) begin
                headPc_d    = tailPc_q;
                headInstr_d = tailInstr_q;
            end
            if (pushOk) begin
                if (wrIdx == 2'd0) begin
                    headPc_d    = inflightPc_q;
                    headInstr_d = imem_rdata;
                end else begin
                    tailPc_d    = inflightPc_q;
                    tailInstr_d = imem_rdata;
                end
            end
            count_d = count_q + {1'b0, pushOk} - {1'b0, pop};
        end
    end

    // State registers with synchronous reset; reset wins over redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc_q     <= ResetWord;
            inflightPc_q  <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            count_q       <= 2'd0;
            headPc_q      <= '0;
            headInstr_q   <= '0;
            tailPc_q      <= '0;
            tailInstr_q   <= '0;
        end else begin
            fetchPc_q     <= fetchPc_d;
            inflightPc_q  <= inflightPc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            headPc_q      <= headPc_d;
            headInstr_q   <= headInstr_d;
            tailPc_q      <= tailPc_d;
            tailInstr_q   <= tailInstr_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: a cycle table for streaming, stall and
// redirect-with-response, followed by hand-written multi-cycle sequences for
// latency-3 redirect, reset mid-transfer, stray responses and PC wrap.
module tb_pc_fetch_unit;

    localparam logic [31:2] A = 30'h2FF0_0000;
    localparam logic [31:2] R = 30'h0000_0400;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:2] redirect_pc;
    logic [31:2] pc_plus4;
    logic        imem_req;
    logic [31:2] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:2] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;

    // Memory model state
    logic        gntEn     = 1'b1;
    logic        injRvalid = 1'b0;
    int          memLat    = 1;
    logic        memPend   = 1'b0;
    logic [31:2] memAddr   = '0;
    int          memCnt    = 0;
    logic        modelRvalid;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic        idReady;
        logic        redir;
        logic [31:2] redirPc;
        logic        expReq;
        logic [31:2] expAddr;
        logic        expValid;
        logic [31:2] expPc;
    } vec_t;

    vec_t vecs[$];

    pc_fetch_unit #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_plus4       (pc_plus4),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .id_ready       (id_ready)
    );

    always #5 clk = ~clk;

    // Memory returns its word address as data after memLat cycles
    assign modelRvalid = memPend && (memCnt == 0);
    assign imem_rvalid = modelRvalid | injRvalid;
    assign imem_gnt    = gntEn;
    assign imem_rdata  = {2'b00, memAddr};

    // Single-slot in-order responder; a grant in the response cycle reloads it
    always @(posedge clk) begin
        if (modelRvalid) memPend <= 1'b0;
        if (memCnt > 0) memCnt <= memCnt - 1;
        if (imem_req && imem_gnt) begin
            memPend <= 1'b1;
            memAddr <= imem_addr;
            memCnt  <= memLat - 1;
        end
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(input logic ir, input logic rd, input logic [31:2] rp,
                                input logic eq, input logic [31:2] ea,
                                input logic ev, input logic [31:2] ep);
        vec_t v;
        v.idReady = ir; v.redir = rd; v.redirPc = rp;
        v.expReq = eq; v.expAddr = ea; v.expValid = ev; v.expPc = ep;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        id_ready       = v.idReady;
        redirect_valid = v.redir;
        redirect_pc    = v.redirPc;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Step until if_valid rises, bounded; a timeout is a failed comparison
    task automatic waitValid(input string name);
        bit seen;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            nextCycle();
            #1;
            if (if_valid) begin
                seen = 1;
                break;
            end
        end
        checkOutput(name, {31'b0, if_valid}, 32'd1);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;

        // Reset state
        repeat (3) nextCycle();
        #1;
        checkOutput("rst_req",    {31'b0, imem_req},  32'd0);
        checkOutput("rst_addr",   {2'b00, imem_addr}, {2'b00, A});
        checkOutput("rst_plus4",  {2'b00, pc_plus4},  {2'b00, A + 30'd1});
        checkOutput("rst_valid",  {31'b0, if_valid},  32'd0);
        checkOutput("rst_ifpc",   {2'b00, if_pc},     32'd0);
        checkOutput("rst_instr",  if_instr,           32'd0);

        // Streaming, 10-cycle stall, redirect coinciding with a response
        vecs.push_back(mk(1, 0, '0, 1, A,          0, '0));
        vecs.push_back(mk(1, 0, '0, 1, A + 30'd1,  0, '0));
        vecs.push_back(mk(1, 0, '0, 1, A + 30'd2,  1, A));
        vecs.push_back(mk(1, 0, '0, 1, A + 30'd3,  1, A + 30'd1));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(0, 0, '0, 0, A + 30'd4, 1, A + 30'd2));
        vecs.push_back(mk(1, 0, '0, 1, A + 30'd4,  1, A + 30'd2));
        vecs.push_back(mk(1, 0, '0, 1, A + 30'd5,  1, A + 30'd3));
        vecs.push_back(mk(1, 0, '0, 1, A + 30'd6,  1, A + 30'd4));
        vecs.push_back(mk(1, 1, R,  0, A + 30'd7,  1, A + 30'd5));
        vecs.push_back(mk(1, 0, '0, 1, R,          0, '0));
        vecs.push_back(mk(1, 0, '0, 1, R + 30'd1,  0, '0));
        vecs.push_back(mk(1, 0, '0, 1, R + 30'd2,  1, R));

        for (int i = 0; i < vecs.size(); i++) begin
            nextCycle();
            rst = 1'b0;
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row%0d_req", i),   {31'b0, imem_req}, {31'b0, vecs[i].expReq});
            checkOutput($sformatf("row%0d_addr", i),  {2'b00, imem_addr}, {2'b00, vecs[i].expAddr});
            checkOutput($sformatf("row%0d_plus4", i), {2'b00, pc_plus4}, {2'b00, vecs[i].expAddr + 30'd1});
            checkOutput($sformatf("row%0d_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].expValid});
            if (vecs[i].expValid) begin
                checkOutput($sformatf("row%0d_ifpc", i),  {2'b00, if_pc}, {2'b00, vecs[i].expPc});
                checkOutput($sformatf("row%0d_instr", i), if_instr,       {2'b00, vecs[i].expPc});
            end
        end

        // Reset with a stale response arriving during reset; switch to 3-cycle memory
        nextCycle();
        rst = 1'b1; redirect_valid = 1'b0; id_ready = 1'b1; memLat = 3;
        #1;
        checkOutput("rst2_req", {31'b0, imem_req}, 32'd0);
        repeat (3) nextCycle();
        nextCycle();
        rst = 1'b0;
        #1;
        checkOutput("rel2_req",   {31'b0, imem_req},  32'd1);
        checkOutput("rel2_addr",  {2'b00, imem_addr}, {2'b00, A});
        checkOutput("rel2_valid", {31'b0, if_valid},  32'd0);

        // Redirect while a latency-3 grant is outstanding
        nextCycle();
        redirect_valid = 1'b1; redirect_pc = 30'h40;
        #1;
        checkOutput("redir3_req", {31'b0, imem_req}, 32'd0);
        nextCycle();
        redirect_valid = 1'b0;
        #1;
        checkOutput("redir3_valid", {31'b0, if_valid},  32'd0);
        checkOutput("redir3_addr",  {2'b00, imem_addr}, 32'h40);
        waitValid("redir3_wait");
        checkOutput("redir3_ifpc",  {2'b00, if_pc}, 32'h40);
        checkOutput("redir3_instr", if_instr,       32'h40);

        // Reset while a grant is outstanding; stale response arrives after release
        nextCycle();
        rst = 1'b1;
        #1;
        checkOutput("rst3_req", {31'b0, imem_req}, 32'd0);
        nextCycle();
        rst = 1'b0;
        #1;
        checkOutput("rel3_addr",  {2'b00, imem_addr}, {2'b00, A});
        checkOutput("rel3_valid", {31'b0, if_valid},  32'd0);
        waitValid("rel3_wait");
        checkOutput("rel3_ifpc",  {2'b00, if_pc}, {2'b00, A});
        checkOutput("rel3_instr", if_instr,       {2'b00, A});

        // Reset and drain, back to 1-cycle memory, withhold grant
        nextCycle();
        rst = 1'b1; memLat = 1;
        repeat (3) nextCycle();
        nextCycle();
        rst = 1'b0; gntEn = 1'b0;
        #1;
        checkOutput("nognt_req", {31'b0, imem_req}, 32'd1);

        // Response with nothing outstanding is ignored
        nextCycle();
        injRvalid = 1'b1;
        #1;
        checkOutput("stray_addr", {2'b00, imem_addr}, {2'b00, A});
        nextCycle();
        injRvalid = 1'b0;
        #1;
        checkOutput("stray_valid", {31'b0, if_valid}, 32'd0);
        checkOutput("stray_req",   {31'b0, imem_req}, 32'd1);
        gntEn = 1'b1;
        waitValid("stray_wait");
        checkOutput("stray_ifpc", {2'b00, if_pc}, {2'b00, A});

        // Fetch PC wrap through 3FFF_FFFF
        nextCycle();
        redirect_valid = 1'b1; redirect_pc = 30'h3FFF_FFFF;
        #1;
        checkOutput("wrap_redir_req", {31'b0, imem_req}, 32'd0);
        nextCycle();
        redirect_valid = 1'b0;
        #1;
        checkOutput("wrap_req0",   {31'b0, imem_req},  32'd1);
        checkOutput("wrap_addr0",  {2'b00, imem_addr}, 32'h3FFF_FFFF);
        checkOutput("wrap_plus40", {2'b00, pc_plus4},  32'd0);
        nextCycle();
        #1;
        checkOutput("wrap_req1",   {31'b0, imem_req},  32'd1);
        checkOutput("wrap_addr1",  {2'b00, imem_addr}, 32'd0);
        checkOutput("wrap_plus41", {2'b00, pc_plus4},  32'd1);
        waitValid("wrap_wait");
        checkOutput("wrap_ifpc0", {2'b00, if_pc}, 32'h3FFF_FFFF);
        nextCycle();
        #1;
        checkOutput("wrap_valid1", {31'b0, if_valid}, 32'd1);
        checkOutput("wrap_ifpc1",  {2'b00, if_pc},    32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch front end that owns the architectural fetch PC. It issues word requests to instruction memory and buffers returned instructions in a 2-entry queue for the decode stage. It exports the sequential successor PC to the next-PC calculator and accepts redirects back from it. All addresses are word addresses (bits [31:2]).

## Interface
- RESET_PC, 32'hBFC0_0000, byte reset vector; bits [1:0] ignored, fetch PC resets to RESET_PC[31:2]
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  one-cycle pulse: replace fetch PC, flush everything younger
- redirect_pc  in  [31:2]  target from next-PC calculator, sampled when redirect_valid=1
- pc_plus4  out  [31:2]  fetch_pc+1 (combinational), fed to next-PC calculator as its sequential input
- imem_req  out  1  fetch request valid
- imem_addr  out  [31:2]  fetch_pc, valid when imem_req=1
- imem_gnt  in  1  request accepted this cycle (handshake completes on imem_req & imem_gnt)
- imem_rvalid  in  1  response valid; responses return in request order, earliest 1 cycle after grant
- imem_rdata  in  [31:0]  instruction word
- if_valid  out  1  queue head valid
- if_pc  out  [31:2]  PC of queue head
- if_instr  out  [31:0]  instruction at queue head
- id_ready  in  1  decode accepts head; pop on if_valid & id_ready

## Operation
- State: fetch_pc[31:2]; 2-entry FIFO of {pc,instr} with count 0..2; outstanding (0/1, accepted request not yet responded); drop (0/1, outstanding response to discard); pc FIFO of in-flight address (1 entry).
- Credit rule: pop = if_valid & id_ready; resp = imem_rvalid & ~drop. imem_req = ~rst & ~redirect_valid & (count + outstanding − pop < 2) & (outstanding == 0 | imem_rvalid). At most one request in flight at a cycle boundary.
- On imem_req & imem_gnt: record fetch_pc as in-flight PC; fetch_pc <= fetch_pc+1 (wraps 30'h3FFF_FFFF -> 0); outstanding stays/becomes 1.
- On imem_rvalid: if drop=1, discard data, clear drop; else push {inflight_pc, imem_rdata}. outstanding cleared unless a new grant occurs the same cycle.
- Push and pop in the same cycle: count unchanged; pop from full queue with push is legal.
- imem_rvalid with outstanding=0: protocol error, ignored (no push).
- Redirect (highest priority): next edge fetch_pc <= redirect_pc, count <= 0, if_valid=0; if outstanding=1 and imem_rvalid=0 this cycle, drop <= 1 (else drop <= 0); no request issued in redirect cycle. Pop in redirect cycle is still reported to decode (head consumed) but irrelevant to state.
- Redirect while drop=1 and response still pending: drop remains 1, fetch_pc updated again.
- Redirect during reset ignored.

## Timing
- Reset values: fetch_pc=RESET_PC[31:2], count=0, outstanding=0, drop=0; outputs imem_req=0, imem_addr=RESET_PC[31:2], if_valid=0, if_pc=0, if_instr=0, pc_plus4=RESET_PC[31:2]+1.
- First imem_req=1 in the first cycle with rst=0.
- Grant-to-if_valid: response cycle +1 (push registered). Single-cycle memory (gnt same cycle, rvalid next) with id_ready=1 sustains 1 instruction/cycle.
- Redirect cycle N: imem_req=0 in N; imem_addr=redirect_pc, imem_req=1 in N+1 (if drop=0 and credits allow; if drop=1, once stale rvalid seen, same cycle permitted). if_valid=0 in N+1.
- Reset asserted mid-transfer: all state cleared next edge; any later stale imem_rvalid ignored (outstanding=0).
- Outputs if_pc/if_instr hold stable while if_valid=1 and id_ready=0.

## Test plan
- Reset release, RESET_PC=BFC0_0000, always-grant 1-cycle memory returning addr as data, id_ready=1 -> imem_addr 2FF0_0000, 2FF0_0001, ... each cycle; if_valid continuous from cycle 3, if_instr increments by 1.
- id_ready=0 for 10 cycles -> count reaches 2, imem_req drops to 0, if_pc/if_instr frozen; on id_ready=1 two heads drain then streaming resumes, no instruction lost or duplicated.
- Redirect to 0000_0100 (word 0x40) while a grant is outstanding with 3-cycle latency -> stale response dropped, if_valid=0 next cycle, next emitted if_pc=0x40.
- Redirect in same cycle as imem_rvalid -> that data not pushed, drop stays 0, request to redirect_pc issued next cycle.
- fetch_pc=3FFF_FFFF granted -> next imem_addr=0, pc_plus4 wraps to 0 then 1.
- rst asserted while outstanding=1, rvalid arrives during/after reset -> no push, if_valid=0, fetch restarts at RESET_PC.
